// File: rtl/uart_seq_trig_pkg.sv
// Purpose: shared types and defaults for the UART sequence trigger controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_seq_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_GAP_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic [7:0] match;
    logic [7:0] mask;   // 1 = don't care
  } seq_entry_t;

endpackage

// File: rtl/uart_seq_trig_gap_timer.sv
// Purpose: saturating inter-byte gap counter with a single-cycle timeout pulse.
// Latency: o_timeout is combinational from the registered count; count updates next clk.
// Backpressure: none; clear wins over count.
// Ports: i_clk, i_rst (sync, active-high), i_clr (zero the count), i_en (count this clk),
//        i_limit (timeout after this many clks; 0 disables), o_timeout (1-clk pulse).
module uart_gap_timer
  import uart_seq_pkg::*;
#(
  parameter int GAP_W = DEFAULT_GAP_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [GAP_W-1:0] i_limit,
  output logic             o_timeout
);

  logic [GAP_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + GAP_W'(1);
    end
  end

  // Count k is held k clks after the last clear, so matching limit-1 here makes
  // the owner act on the edge exactly limit clks after the last advance.
  assign o_timeout = i_en && (i_limit != '0) && (r_cnt == i_limit - GAP_W'(1));

endmodule

// File: rtl/uart_seq_trig.sv
// Purpose: steps the UART datapath through a table of match/mask bytes, pulses seq_trig on full match.
// Latency: o_seq_trig 1 clk after the final i_UARTtrig; table writes visible 1 clk after i_cfg_we.
// Backpressure: none; i_cfg_we ignored while armed (WAIT), i_UARTtrig ignored outside WAIT.
// Ports: i_cfg_* table write port, i_seq_len / i_gap_limit live config, i_arm / i_disarm control,
//        i_UARTtrig datapath match pulse; o_match / o_mask current entry, o_seq_idx, o_armed,
//        o_seq_trig (pulse), o_triggered (sticky in DONE).
module uart_seq_trig
  import uart_seq_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int GAP_W = DEFAULT_GAP_W
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   i_cfg_addr,
  input  logic [7:0]                 i_cfg_match,
  input  logic [7:0]                 i_cfg_mask,
  input  logic [$clog2(DEPTH):0]     i_seq_len,
  input  logic [GAP_W-1:0]           i_gap_limit,
  input  logic                       i_arm,
  input  logic                       i_disarm,
  input  logic                       i_UARTtrig,
  output logic [7:0]                 o_match,
  output logic [7:0]                 o_mask,
  output logic [$clog2(DEPTH)-1:0]   o_seq_idx,
  output logic                       o_armed,
  output logic                       o_seq_trig,
  output logic                       o_triggered
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = IDX_W + 1;
  localparam seq_entry_t RST_ENTRY = '{match: 8'h00, mask: 8'hFF};

  seq_state_t       r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_seq_trig;
  seq_entry_t       r_tbl [DEPTH];

  seq_state_t       w_nxt_state;
  logic [IDX_W-1:0] w_nxt_idx;
  logic             w_nxt_trig;
  logic [LEN_W-1:0] w_eff_len;
  logic             w_last;
  logic             w_timeout;
  logic             w_gap_en;
  logic             w_gap_clr;
  logic             w_tbl_we;

  // Live length: 0 behaves as 1, anything beyond the table clamps to DEPTH.
  always_comb begin
    w_eff_len = i_seq_len;
    if (i_seq_len == '0) begin
      w_eff_len = LEN_W'(1);
    end else if (i_seq_len > LEN_W'(DEPTH)) begin
      w_eff_len = LEN_W'(DEPTH);
    end
  end

  // >= rather than == so that shrinking seq_len below the current index
  // lets the very next match complete the sequence.
  assign w_last = ({1'b0, r_idx} >= (w_eff_len - LEN_W'(1)));

  assign w_gap_en  = (r_state == WAIT) && (r_idx != '0) && (i_gap_limit != '0);
  assign w_gap_clr = i_arm || i_disarm || i_UARTtrig || w_timeout || (r_state != WAIT);
  assign w_tbl_we  = i_cfg_we && (r_state != WAIT);

  uart_gap_timer #(
    .GAP_W (GAP_W)
  ) u_gap (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (w_gap_clr),
    .i_en      (w_gap_en),
    .i_limit   (i_gap_limit),
    .o_timeout (w_timeout)
  );

  // Priority: disarm > arm > UARTtrig > timeout.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_trig  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!i_disarm && i_arm) begin
          w_nxt_state = WAIT;
          w_nxt_idx   = '0;
        end
      end
      WAIT: begin
        if (i_disarm) begin
          w_nxt_state = IDLE;
          w_nxt_idx   = '0;
        end else if (i_arm) begin
          w_nxt_idx = '0;
        end else if (i_UARTtrig) begin
          if (w_last) begin
            w_nxt_state = DONE;
            w_nxt_trig  = 1'b1;
          end else begin
            w_nxt_idx = r_idx + IDX_W'(1);
          end
        end else if (w_timeout) begin
          w_nxt_idx = '0;
        end
      end
      DONE: begin
        if (i_disarm) begin
          w_nxt_state = IDLE;
          w_nxt_idx   = '0;
        end else if (i_arm) begin
          w_nxt_state = WAIT;
          w_nxt_idx   = '0;
        end
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_idx   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_seq_trig <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tbl[i] <= RST_ENTRY;
      end
    end else begin
      r_state    <= w_nxt_state;
      r_idx      <= w_nxt_idx;
      r_seq_trig <= w_nxt_trig;
      if (w_tbl_we) begin
        r_tbl[i_cfg_addr] <= '{match: i_cfg_match, mask: i_cfg_mask};
      end
    end
  end

  assign o_match     = r_tbl[r_idx].match;
  assign o_mask      = r_tbl[r_idx].mask;
  assign o_seq_idx   = r_idx;
  assign o_armed     = (r_state == WAIT);
  assign o_seq_trig  = r_seq_trig;
  assign o_triggered = (r_state == DONE);

endmodule

// File: tb/tb_uart_seq_trig.sv
// Purpose: directed self-checking bench for uart_seq_trig with a seq_trig scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_seq_trig;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [7:0]  cfg_match;
  logic [7:0]  cfg_mask;
  logic [2:0]  seq_len;
  logic [23:0] gap_limit;
  logic        arm;
  logic        disarm;
  logic        uart_trig;
  logic [7:0]  match_o;
  logic [7:0]  mask_o;
  logic [1:0]  seq_idx;
  logic        armed;
  logic        seq_trig;
  logic        triggered;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp_q [$];

  uart_seq_trig #(.DEPTH(4), .GAP_W(24)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cfg_we    (cfg_we),
    .i_cfg_addr  (cfg_addr),
    .i_cfg_match (cfg_match),
    .i_cfg_mask  (cfg_mask),
    .i_seq_len   (seq_len),
    .i_gap_limit (gap_limit),
    .i_arm       (arm),
    .i_disarm    (disarm),
    .i_UARTtrig  (uart_trig),
    .o_match     (match_o),
    .o_mask      (mask_o),
    .o_seq_idx   (seq_idx),
    .o_armed     (armed),
    .o_seq_trig  (seq_trig),
    .o_triggered (triggered)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every seq_trig pulse must match the next expected cycle.
  always @(negedge clk) begin
    if (seq_trig === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        assert (0) else begin
          failures++;
          $error("FAIL seq_trig_unexpected cycle=%0d expected=none", cyc);
        end
      end else begin
        int e;
        e = exp_q.pop_front();
        assert (cyc === e) else begin
          failures++;
          $error("FAIL seq_trig_cycle observed=%0d expected=%0d", cyc, e);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] m, input logic [7:0] k);
    cfg_we = 1'b1; cfg_addr = a; cfg_match = m; cfg_mask = k;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic pulse_trig(input bit final_byte);
    if (final_byte) exp_q.push_back(cyc + 1);
    uart_trig = 1'b1; tick(); uart_trig = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_match = '0; cfg_mask = '0;
    seq_len = 3'd2; gap_limit = '0; arm = 1'b0; disarm = 1'b0; uart_trig = 1'b0;
    tick(3);

    // Reset values
    chk("rst_match", match_o, 8'h00);
    chk("rst_mask", mask_o, 8'hFF);
    chk("rst_idx", seq_idx, 0);
    chk("rst_armed", armed, 0);
    chk("rst_seq_trig", seq_trig, 0);
    chk("rst_triggered", triggered, 0);
    rst = 1'b0;
    tick();

    // Full two-byte sequence, no gap timeout
    cfg_write(2'd0, 8'h55, 8'h00);
    cfg_write(2'd1, 8'hAA, 8'h0F);
    chk("tbl_match0", match_o, 8'h55);
    chk("tbl_mask0", mask_o, 8'h00);
    pulse_arm();
    chk("armed_after_arm", armed, 1);
    tick(200);
    pulse_trig(0);
    chk("adv_idx1", seq_idx, 1);
    chk("adv_match1", match_o, 8'hAA);
    chk("adv_mask1", mask_o, 8'h0F);
    tick(200);
    pulse_trig(1);
    chk("done_triggered", triggered, 1);
    chk("done_armed", armed, 0);
    chk("done_idx_hold", seq_idx, 1);
    tick(3);
    // Match pulse in DONE is ignored: no extra seq_trig, state unchanged
    pulse_trig(0);
    chk("done_ignore_trig", triggered, 1);
    tick(2);

    // Gap timeout: returns to entry 0 exactly gap_limit clks after the advance
    cfg_write(2'd2, 8'hC3, 8'h00);
    seq_len = 3'd3; gap_limit = 24'd100;
    pulse_arm();
    pulse_trig(0);
    tick(99);
    chk("gap_before_timeout", seq_idx, 1);
    tick();
    chk("gap_timeout_idx", seq_idx, 0);
    chk("gap_timeout_armed", armed, 1);
    // Match on the timeout cycle advances instead
    pulse_trig(0);
    tick(99);
    pulse_trig(0);
    chk("gap_trig_wins", seq_idx, 2);

    // Priority: disarm beats arm and a completing match
    gap_limit = '0;
    disarm = 1'b1; arm = 1'b1; uart_trig = 1'b1;
    tick();
    disarm = 1'b0; arm = 1'b0; uart_trig = 1'b0;
    chk("prio_disarm_armed", armed, 0);
    chk("prio_disarm_trgd", triggered, 0);
    chk("prio_disarm_idx", seq_idx, 0);
    pulse_arm();
    pulse_trig(0);
    chk("prio_pre_idx", seq_idx, 1);
    arm = 1'b1; uart_trig = 1'b1;
    tick();
    arm = 1'b0; uart_trig = 1'b0;
    chk("prio_arm_idx", seq_idx, 0);
    chk("prio_arm_armed", armed, 1);

    // Config lockout in WAIT, accepted in DONE
    cfg_write(2'd0, 8'h33, 8'h00);
    chk("lockout_wait", match_o, 8'h55);
    seq_len = 3'd1;
    pulse_trig(1);
    chk("len1_done", triggered, 1);
    cfg_write(2'd0, 8'h33, 8'h00);
    chk("write_in_done", match_o, 8'h33);

    // Length clamp: 0 behaves as 1
    seq_len = 3'd0;
    pulse_arm();
    pulse_trig(1);
    chk("len0_done", triggered, 1);
    // Length clamp: 7 behaves as DEPTH=4
    seq_len = 3'd7;
    pulse_arm();
    pulse_trig(0);
    pulse_trig(0);
    pulse_trig(0);
    chk("len7_idx3", seq_idx, 3);
    chk("len7_not_done", triggered, 0);
    pulse_trig(1);
    chk("len7_done", triggered, 1);

    // Reset mid-sequence restores the table too
    pulse_arm();
    pulse_trig(0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_idx", seq_idx, 0);
    chk("midrst_armed", armed, 0);
    chk("midrst_match", match_o, 8'h00);
    chk("midrst_mask", mask_o, 8'hFF);

    tick(3);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
